// File: rtl/md_pad_responder.sv
// Device side of the Mega Drive pad read protocol: answers the host select line with active-low pin levels.
// Build option MD_PAD_SIX_BTN_EN adds the 6-button phase counter and ID pattern; without it this is a 3-button pad.
module md_pad_responder #(
    parameter int TIMEOUT_CYCLES = 72000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        mdsel,
    input  logic [11:0] buttons,
    output logic [5:0]  pad_out,
    output logic [2:0]  phase,
    output logic        id_active
);

    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam int B_RIGHT = 0;
    localparam int B_LEFT  = 1;
    localparam int B_DOWN  = 2;
    localparam int B_UP    = 3;
    localparam int B_B     = 4;
    localparam int B_C     = 5;
    localparam int B_A     = 6;
    localparam int B_START = 7;

    logic [NS-1:0] sync_q;
    logic          sel_s;
    logic          sel_d;
    logic [11:0]   btn_q;
    logic [5:0]    pad_nxt;
    logic          id_nxt;

    assign sel_s = sync_q[NS-1];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync_q <= '1;
            sel_d  <= 1'b1;
            btn_q  <= '0;
        end else begin
            sync_q <= {sync_q[NS-2:0], mdsel};
            sel_d  <= sel_s;
            btn_q  <= buttons;
        end
    end

`ifdef MD_PAD_SIX_BTN_EN
    localparam int B_Z    = 8;
    localparam int B_Y    = 9;
    localparam int B_X    = 10;
    localparam int B_MODE = 11;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] timer_q;
    logic [2:0]    phase_q;
    logic [2:0]    phase_nxt;
    logic          fall;
    logic          rise;

    assign fall = sel_d & ~sel_s;
    assign rise = ~sel_d & sel_s;

    // Timeout is applied before the edge so an edge in the expiry cycle restarts at phase 1.
    always_comb begin
        phase_nxt = (timer_q == T_MAX) ? 3'd0 : phase_q;
        if (fall) begin
            phase_nxt = (phase_nxt >= 3'd4) ? 3'd4 : phase_nxt + 3'd1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            timer_q <= '0;
            phase_q <= 3'd0;
        end else begin
            if (fall || rise) begin
                timer_q <= '0;
            end else if (timer_q != T_MAX) begin
                timer_q <= timer_q + 1'b1;
            end
            phase_q <= phase_nxt;
        end
    end

    assign phase = phase_q;

    // The mux looks at the upcoming phase so a falling edge and its row switch land on the same cycle.
    always_comb begin
        pad_nxt = 6'b111111;
        id_nxt  = 1'b0;
        if (sel_s) begin
            if (phase_nxt == 3'd3) begin
                pad_nxt = {~btn_q[B_C], ~btn_q[B_B], ~btn_q[B_MODE], ~btn_q[B_X], ~btn_q[B_Y], ~btn_q[B_Z]};
            end else begin
                pad_nxt = {~btn_q[B_C], ~btn_q[B_B], ~btn_q[B_RIGHT], ~btn_q[B_LEFT], ~btn_q[B_DOWN], ~btn_q[B_UP]};
            end
        end else begin
            if (phase_nxt == 3'd3) begin
                pad_nxt = {~btn_q[B_START], ~btn_q[B_A], 4'b0000};
                id_nxt  = 1'b1;
            end else if (phase_nxt == 3'd4) begin
                pad_nxt = {~btn_q[B_START], ~btn_q[B_A], 4'b1111};
            end else begin
                pad_nxt = {~btn_q[B_START], ~btn_q[B_A], 2'b00, ~btn_q[B_DOWN], ~btn_q[B_UP]};
            end
        end
    end
`else
    logic unused_ext;

    // Z/Y/X/Mode have no pins to drive on a 3-button pad.
    assign unused_ext = ^btn_q[11:8];
    assign phase      = 3'd0;

    always_comb begin
        pad_nxt = 6'b111111;
        id_nxt  = 1'b0;
        if (sel_s) begin
            pad_nxt = {~btn_q[B_C], ~btn_q[B_B], ~btn_q[B_RIGHT], ~btn_q[B_LEFT], ~btn_q[B_DOWN], ~btn_q[B_UP]};
        end else begin
            pad_nxt = {~btn_q[B_START], ~btn_q[B_A], 2'b00, ~btn_q[B_DOWN], ~btn_q[B_UP]};
        end
    end
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pad_out   <= 6'b111111;
            id_active <= 1'b0;
        end else begin
            pad_out   <= pad_nxt;
            id_active <= id_nxt;
        end
    end

endmodule
